// File: rtl/uart_tx_feeder.sv
// Buffers host words in a circular FIFO and paces them into a UART transmitter,
// one frame at a time, with a fixed idle gap after each completed frame.
module uart_tx_feeder #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH       = 8,
  parameter int FRAME_GAP        = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  input  logic [INPUT_DATA_WIDTH-1:0] s_data,
  output logic                        s_ready,
  output logic                        tx_enable,
  output logic [INPUT_DATA_WIDTH-1:0] tx_data,
  input  logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (FRAME_GAP > 0) ? GAP_W'(FRAME_GAP - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [INPUT_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [GAP_W-1:0]            gap_cnt;
  logic [GAP_W-1:0]            gap_cnt_nxt;
  logic                        push;
  logic                        pop;
  logic                        launch_ok;
  logic                        tx_done_nxt;

  assign s_ready   = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push      = s_valid && s_ready;
  assign launch_ok = (fifo_count != '0) && !tx_busy;

  // Storage array carries no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Launch outputs are registered, so the FIFO head is only seen one clock after it lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      tx_enable <= 1'b0;
      tx_done   <= 1'b0;
      tx_data   <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      tx_enable <= pop;
      tx_done   <= tx_done_nxt;
      gap_cnt   <= gap_cnt_nxt;
      if (pop) begin
        tx_data <= fifo_mem[rd_ptr];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch_ok) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = (FRAME_GAP == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Gap counter restarts from zero on every entry to GAP because it idles at zero elsewhere.
  always_comb begin
    pop         = 1'b0;
    tx_done_nxt = 1'b0;
    gap_cnt_nxt = '0;
    case (state)
      IDLE:      pop         = launch_ok;
      WAIT_DONE: tx_done_nxt = !tx_busy;
      GAP:       gap_cnt_nxt = gap_cnt + 1'b1;
      default:   pop         = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: a behavioural UART busy model answers each
// launch, and every launched word is matched against the words the host handed over.
module tb_uart_tx_feeder;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         tx_enable;
  logic [W-1:0] tx_data;
  logic         tx_busy;
  logic         tx_done;
  logic [3:0]   fifo_count;

  int           checks       = 0;
  int           errors       = 0;
  logic [W-1:0] sb [$];
  bit           mon_on       = 1'b0;
  bit           force_busy   = 1'b0;
  bit           in_frame     = 1'b0;
  bit           after_done   = 1'b0;
  int           busy_len     = 88;
  int           since_done   = 0;
  int           done_count   = 0;
  int           launch_count = 0;
  logic [W-1:0] hold_data    = '0;
  int           l0;
  int           d0;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .INPUT_DATA_WIDTH(W),
    .FIFO_DEPTH(DEPTH),
    .FRAME_GAP(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .tx_enable(tx_enable),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic [W-1:0] data, input int max_wait);
    bit accepted;
    accepted = 1'b0;
    s_valid  = 1'b1;
    s_data   = data;
    for (int i = 0; i < max_wait; i++) begin
      if (s_ready) begin
        tick();
        accepted = 1'b1;
        break;
      end
      tick();
    end
    s_valid = 1'b0;
    checkOutput("push_accept", 32'(accepted), 32'd1);
  endtask

  task automatic waitDrain(input int max_cycles);
    int quiet;
    bit ok;
    quiet = 0;
    ok    = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (sb.size() == 0 && !in_frame && !tx_busy && fifo_count == 0 && !tx_enable) quiet++;
      else quiet = 0;
      if (quiet >= 8) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("drain", 32'(ok), 32'd1);
  endtask

  // UART model: busy rises the clock after the enable pulse and stays high busy_len clocks.
  initial begin
    int  left;
    bit  pend;
    left    = 0;
    pend    = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (left > 0) left--;
      if (pend) begin
        pend = 1'b0;
        left = busy_len;
      end
      if (tx_enable === 1'b1) pend = 1'b1;
      tx_busy = force_busy || (left > 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (!reset) begin
          sb.delete();
          in_frame   = 1'b0;
          after_done = 1'b0;
        end else begin
          checkOutput("enable_while_busy", 32'(tx_enable & tx_busy), 32'd0);
          if (tx_done) begin
            checkOutput("done_in_frame", 32'(in_frame), 32'd1);
            in_frame   = 1'b0;
            done_count++;
            after_done = 1'b1;
            since_done = 0;
          end else if (tx_enable) begin
            if (after_done) checkOutput("frame_gap", 32'(since_done >= GAP), 32'd1);
            after_done = 1'b0;
            checkOutput("launch_has_word", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) checkOutput("launch_order", 32'(tx_data), 32'(sb.pop_front()));
            in_frame  = 1'b1;
            hold_data = tx_data;
            launch_count++;
          end else begin
            if (after_done) since_done++;
            if (in_frame) checkOutput("tx_data_hold", 32'(tx_data), 32'(hold_data));
          end
          if (s_valid && s_ready) sb.push_back(s_data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    tick();
    tick();
    reset  = 1'b1;
    mon_on = 1'b1;
    tick();
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_ready", 32'(s_ready), 32'd1);
    checkOutput("rst_enable", 32'(tx_enable), 32'd0);
    checkOutput("rst_done", 32'(tx_done), 32'd0);
    checkOutput("rst_data", 32'(tx_data), 32'd0);
    waitCycles(3);

    // single word with a long frame
    busy_len = 88;
    l0 = launch_count;
    d0 = done_count;
    applyStimulus(8'hA5, 10);
    checkOutput("no_bypass", 32'(tx_enable), 32'd0);
    checkOutput("one_count", 32'(fifo_count), 32'd1);
    tick();
    checkOutput("a5_enable", 32'(tx_enable), 32'd1);
    checkOutput("a5_data", 32'(tx_data), 32'hA5);
    checkOutput("a5_popped", 32'(fifo_count), 32'd0);
    tick();
    checkOutput("a5_pulse", 32'(tx_enable), 32'd0);
    waitDrain(400);
    checkOutput("a5_launches", 32'(launch_count - l0), 32'd1);
    checkOutput("a5_dones", 32'(done_count - d0), 32'd1);

    // fill to full while the transmitter is busy
    busy_len   = 5;
    force_busy = 1'b1;
    waitCycles(2);
    l0 = launch_count;
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 10);
    s_valid = 1'b1;
    s_data  = 8'h09;
    waitCycles(3);
    checkOutput("full_ready", 32'(s_ready), 32'd0);
    checkOutput("full_count", 32'(fifo_count), 32'd8);
    checkOutput("full_no_launch", 32'(launch_count - l0), 32'd0);
    force_busy = 1'b0;
    applyStimulus(8'h09, 200);
    waitDrain(2000);
    checkOutput("fill_launches", 32'(launch_count - l0), 32'd9);

    // push on the same clock as the launch pop
    force_busy = 1'b1;
    waitCycles(2);
    applyStimulus(8'h31, 10);
    applyStimulus(8'h32, 10);
    applyStimulus(8'h33, 10);
    checkOutput("pp_pre_count", 32'(fifo_count), 32'd3);
    tick();
    force_busy = 1'b0;
    s_valid    = 1'b1;
    s_data     = 8'h34;
    tick();
    s_valid = 1'b0;
    checkOutput("pp_count", 32'(fifo_count), 32'd3);
    checkOutput("pp_enable", 32'(tx_enable), 32'd1);
    checkOutput("pp_data", 32'(tx_data), 32'h31);
    waitDrain(1000);

    // transmitter stuck busy
    force_busy = 1'b1;
    waitCycles(2);
    l0 = launch_count;
    applyStimulus(8'h5A, 10);
    waitCycles(1000);
    checkOutput("stuck_no_launch", 32'(launch_count - l0), 32'd0);
    checkOutput("stuck_count", 32'(fifo_count), 32'd1);
    force_busy = 1'b0;
    waitDrain(500);
    checkOutput("stuck_released", 32'(launch_count - l0), 32'd1);

    // reset in the middle of a frame
    busy_len = 40;
    for (int i = 0; i < 5; i++) applyStimulus(8'h41 + 8'(i), 10);
    waitCycles(4);
    checkOutput("mid_count", 32'(fifo_count), 32'd4);
    checkOutput("mid_in_frame", 32'(in_frame), 32'd1);
    d0 = done_count;
    l0 = launch_count;
    force_busy = 1'b1;
    reset      = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("mid_rst_ready", 32'(s_ready), 32'd1);
    checkOutput("mid_rst_data", 32'(tx_data), 32'd0);
    applyStimulus(8'h77, 10);
    waitCycles(30);
    checkOutput("mid_no_done", 32'(done_count - d0), 32'd0);
    checkOutput("mid_no_launch", 32'(launch_count - l0), 32'd0);
    checkOutput("mid_new_count", 32'(fifo_count), 32'd1);
    force_busy = 1'b0;
    waitDrain(500);
    checkOutput("mid_relaunch", 32'(launch_count - l0), 32'd1);
    checkOutput("mid_one_done", 32'(done_count - d0), 32'd1);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 8, meaning width of one UART data word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning word capacity; power of two, at least 2.
REQ-003 SHALL have parameter FRAME_GAP, default 2, meaning idle clocks between tx_busy falling and the next tx_enable.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets).
REQ-006 SHALL have port s_valid  input  1  host offers a word.
REQ-007 SHALL have port s_data  input  INPUT_DATA_WIDTH  host word.
REQ-008 SHALL have port s_ready  output  1  feeder can accept; a word transfers on a clock where s_valid and s_ready are both 1.
REQ-009 SHALL have port tx_enable  output  1  one-clock launch pulse to the UART transmitter enable.
REQ-010 SHALL have port tx_data  output  INPUT_DATA_WIDTH  word driven to the UART transmitter i_data.
REQ-011 SHALL have port tx_busy  input  1  UART transmitter o_busy.
REQ-012 SHALL have port tx_done  output  1  one-clock pulse when a launched frame completes.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently stored.

Function
REQ-014 SHALL store accepted words in a circular FIFO with read and write pointers that wrap modulo FIFO_DEPTH.
REQ-015 SHALL drive s_ready = (fifo_count < FIFO_DEPTH); a word offered while full is not accepted and not lost, because the host holds it.
REQ-016 SHALL update fifo_count by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-017 SHALL NOT bypass an empty FIFO: a word accepted at edge N is readable after edge N, and tx_enable rises no earlier than after edge N+1 (minimum latency 2 clocks).
REQ-018 SHALL implement the FSM IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
REQ-019 SHALL move IDLE->LAUNCH when fifo_count != 0 and tx_busy == 0.
REQ-020 On that transition, SHALL register tx_data = head word, pop it, and set tx_enable = 1.
REQ-021 In LAUNCH, SHALL clear tx_enable and go to WAIT_BUSY; tx_enable is high for exactly one clock per word.
REQ-022 In WAIT_BUSY, SHALL wait for tx_busy == 1, then go to WAIT_DONE.
REQ-023 In WAIT_DONE, SHALL wait for tx_busy == 0, then pulse tx_done for one clock and go to GAP.
REQ-024 In GAP, SHALL count FRAME_GAP clocks, then go to IDLE; FRAME_GAP == 0 goes straight to IDLE.
REQ-025 SHALL NEVER assert tx_enable while tx_busy == 1.
REQ-026 SHALL hold tx_data stable from the tx_enable pulse until tx_done, as the transmitter samples i_data throughout the frame.
REQ-027 SHALL keep accepting host pushes in every FSM state, subject only to REQ-015.
REQ-028 SHALL keep words in order: launch order equals acceptance order, with no duplication or loss.

Reset
REQ-029 While reset == 0 at a rising edge, SHALL force: state IDLE, pointers 0, fifo_count 0, tx_enable 0, tx_done 0, tx_data all-zero, gap counter 0.
REQ-030 s_ready SHALL read 1 in the first clock after reset release.
REQ-031 Reset mid-frame SHALL discard the stored word and all FIFO contents, with no tx_done for the aborted frame.
REQ-032 After reset mid-frame, the feeder SHALL NOT launch again until tx_busy == 0 (REQ-019 guards it).

Verification
REQ-033 Reset then idle: hold reset=0 two clocks, release -> fifo_count=0, s_ready=1, tx_enable=0, tx_done=0.
REQ-034 Single word: push 0xA5 at edge N with tx_busy=0 -> tx_enable=1 and tx_data=0xA5 after edge N+1. Model busy high for 88 clocks -> one tx_done pulse, then tx_enable stays low at least FRAME_GAP clocks.
REQ-035 Fill to full: push 9 words 0x01..0x09 back-to-back with tx_busy held 1 -> 8 accepted, s_ready=0, fifo_count=8. Release busy -> launches 0x01..0x08 in order, then 0x09 accepted when space frees.
REQ-036 Simultaneous push/pop: push on the same clock as the IDLE->LAUNCH pop with fifo_count=3 -> fifo_count stays 3.
REQ-037 Busy stuck: tx_busy held 1 for 1000 clocks with FIFO non-empty -> tx_enable never asserts. tx_enable & tx_busy is never 1 on any clock.
REQ-038 Reset mid-frame: reset=0 for one clock during WAIT_DONE with fifo_count=4 -> fifo_count=0, no tx_done. Next launch occurs only after a new push and tx_busy=0.
